lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 480: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 2 / 41 / 2: horizontal front porch, sync and back porch in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 272: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 2 / 10 / 2: vertical front porch, sync and back porch in lines.
REQ-005 Parameter LEAD, default 2, range 0..4: cycles by which pixel_req precedes lcd__display_enable.
REQ-006 Parameter CNT_W, default 11: width of the x/y counters.
REQ-007 clk  in  1  pixel clock, single clock domain.
REQ-008 clk__enable  in  1  clock enable; all state advances only when it is high.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 run  in  1  timing enable; sampled only at frame boundary.
REQ-011 lcd__hsync_n  out  1  horizontal sync, active low.
REQ-012 lcd__vsync_n  out  1  vertical sync, active low.
REQ-013 lcd__display_enable  out  1  high during active pixels.
REQ-014 pixel_req  out  1  fetch strobe, LEAD cycles ahead of display_enable.
REQ-015 pixel_x / pixel_y  out  CNT_W  coordinate of the pixel requested by pixel_req.
REQ-016 frame_start / line_start  out  1  single-cycle pulses.
REQ-017 frame_count  out  8  frames completed, wrapping.

Function
REQ-018 Counters h_cnt, v_cnt SHALL advance on clk only when clk__enable is high; a low clk__enable freezes every output.
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0, incrementing v_cnt on wrap.
REQ-020 v_cnt SHALL count 0..V_TOTAL-1 and wrap to 0 on the same cycle h_cnt wraps at v_cnt = V_TOTAL-1.
REQ-021 Region order per line SHALL be active (h_cnt 0..H_ACTIVE-1), front porch, sync, back porch; vertical likewise.
REQ-022 All outputs SHALL be registered; lcd__display_enable SHALL be high exactly when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, one cycle latency from the counters.
REQ-023 lcd__hsync_n SHALL be low for exactly H_SYNC clocks per line, starting H_ACTIVE+H_FP after line start.
REQ-024 lcd__vsync_n SHALL be low for exactly V_SYNC whole lines, transitioning at h_cnt = 0.
REQ-025 pixel_req SHALL assert exactly LEAD enabled cycles before each display_enable-high cycle, with pixel_x/pixel_y giving that pixel; LEAD = 0 makes it coincident.
REQ-026 pixel_req SHALL span line wrap correctly (requests for x = 0 issued during previous line's back porch); pixel_x/pixel_y SHALL hold their last value when pixel_req is low.
REQ-027 line_start SHALL pulse for one enabled cycle when h_cnt = 0; frame_start additionally requires v_cnt = 0.
REQ-028 State machine IDLE/RUN: IDLE holds counters at 0, syncs deasserted (high), display_enable and pixel_req low, no pulses.
REQ-029 IDLE -> RUN when run = 1; first enabled cycle in RUN is h_cnt = 0, v_cnt = 0 with frame_start.
REQ-030 RUN -> IDLE only when run = 0 at the final clock of a frame; run deassertion mid-frame SHALL complete the frame.
REQ-031 frame_count SHALL increment on each completed frame, wrapping 255 -> 0.
REQ-032 Elaboration SHALL fail if H_ACTIVE+... or V_TOTAL exceeds 2^CNT_W, or LEAD > H_FP+H_SYNC+H_BP.

Reset
REQ-033 reset SHALL take priority over clk__enable and run, forcing IDLE, counters 0, frame_count 0, hsync_n/vsync_n high, display_enable/pixel_req/pulses low, pixel_x/pixel_y 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse extension on the following cycle.

Structure
REQ-035 Region encoding (ACTIVE, FP, SYNC, BP) and state encoding (IDLE, RUN) SHALL live in shared package lcd_timing_pkg.
REQ-036 One sub-module lcd_timing_axis SHALL implement a single counter-and-region decoder, instantiated once horizontal and once vertical.

Verification
REQ-037 Defaults, run = 1 from reset: H_TOTAL = 525 clocks between line_start pulses, V_TOTAL = 286 lines, hsync_n low 41 clocks, vsync_n low 10 lines.
REQ-038 Defaults: count display_enable-high cycles per frame = 480*272 = 130560; pixel_req count equal, each LEAD = 2 cycles earlier with matching x/y.
REQ-039 clk__enable toggled 1-of-3 cycles: all outputs identical sequence to REQ-037 stretched by 3, no glitch on frozen cycles.
REQ-040 run dropped at v_cnt = 100: frame completes, frame_count increments once, then IDLE with syncs high; run reasserted -> frame_start on next enabled cycle.
REQ-041 reset pulsed during hsync at line 50: next cycle hsync_n = 1, all counters 0, frame_count 0.
REQ-042 H_ACTIVE = 4, H_FP = 1, H_SYNC = 1, H_BP = 1, V_ACTIVE = 2, V_FP/V_SYNC/V_BP = 1, LEAD = 3: pixel_req for (0,y+1) issued in line y porch; frame of 35 clocks.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared encodings and helpers for the LCD timing generator.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int FRAME_CNT_W = 8;
    localparam int LEAD_MAX    = 4;

    // True when a counter of w bits can represent every value 0..total-1.
    function automatic logic fits(input int total, input int w);
        return (total <= (1 << w));
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-side LCD timing bundle; the generator drives it, the panel consumes it.
interface lcd_timing_gen_if;

    logic hsync_n;
    logic vsync_n;
    logic display_enable;

    modport master (
        output hsync_n,
        output vsync_n,
        output display_enable
    );

    modport slave (
        input hsync_n,
        input vsync_n,
        input display_enable
    );

endinterface

// File: rtl/lcd_timing_axis.sv
// One timing axis: wrapping position counter plus active/front-porch/sync/back-porch decoder.
module lcd_timing_axis
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = 480,
    parameter int FP     = 2,
    parameter int SYNC   = 41,
    parameter int BP     = 2,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] cnt,
    output region_e      region,
    output logic         last
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST_POS = W'(TOTAL - 1);

    logic [W-1:0] cnt_r;

    // Position counter, advanced only on qualified steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (step) begin
            if (cnt_r == LAST_POS) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end
    end

    // Region boundaries compared in int so a full-range counter cannot alias.
    always_comb begin
        region = REG_BP;
        if (int'(cnt_r) < ACTIVE) begin
            region = REG_ACTIVE;
        end else if (int'(cnt_r) < ACTIVE + FP) begin
            region = REG_FP;
        end else if (int'(cnt_r) < ACTIVE + FP + SYNC) begin
            region = REG_SYNC;
        end else begin
            region = REG_BP;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == LAST_POS);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: registered syncs/enable plus a pixel fetch strobe LEAD clocks ahead.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int LEAD     = 2,
    parameter int CNT_W    = 11
) (
    input  logic                   clk,
    input  logic                   clk__enable,
    input  logic                   reset,
    input  logic                   run,
    lcd_timing_gen_if.master       lcd,
    output logic                   pixel_req,
    output logic [CNT_W-1:0]       pixel_x,
    output logic [CNT_W-1:0]       pixel_y,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_BLANK = H_FP + H_SYNC + H_BP;

    if (!fits(H_TOTAL, CNT_W)) begin : g_bad_h_total
        $error("lcd_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (!fits(V_TOTAL, CNT_W)) begin : g_bad_v_total
        $error("lcd_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if ((LEAD < 0) || (LEAD > LEAD_MAX) || (LEAD > H_BLANK)) begin : g_bad_lead
        $error("lcd_timing_gen: LEAD out of range or longer than horizontal blanking");
    end

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic                     running_s;
    logic                     h_step_s;
    logic                     v_step_s;
    logic                     frame_end_s;
    logic [CNT_W-1:0]         h_cnt_s;
    logic [CNT_W-1:0]         v_cnt_s;
    region_e                  h_region_s;
    region_e                  v_region_s;
    logic                     h_last_s;
    logic                     v_last_s;
    logic [CNT_W-1:0]         lead_h_s;
    logic [CNT_W-1:0]         lead_v_s;
    logic                     lead_ok_s;
    logic                     hsync_n_s;
    logic                     vsync_n_s;
    logic                     de_s;
    logic                     pixel_req_s;
    logic [CNT_W-1:0]         pixel_x_s;
    logic [CNT_W-1:0]         pixel_y_s;
    logic                     frame_start_s;
    logic                     line_start_s;
    logic                     hsync_n_r;
    logic                     vsync_n_r;
    logic                     de_r;
    logic                     pixel_req_r;
    logic [CNT_W-1:0]         pixel_x_r;
    logic [CNT_W-1:0]         pixel_y_r;
    logic                     frame_start_r;
    logic                     line_start_r;
    logic [FRAME_CNT_W-1:0]   frame_count_r;

    assign running_s   = (state_r == ST_RUN);
    assign h_step_s    = clk__enable && running_s;
    assign v_step_s    = h_step_s && h_last_s;
    assign frame_end_s = v_step_s && v_last_s;

    lcd_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (h_step_s),
        .cnt    (h_cnt_s),
        .region (h_region_s),
        .last   (h_last_s)
    );

    lcd_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (v_step_s),
        .cnt    (v_cnt_s),
        .region (v_region_s),
        .last   (v_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (clk__enable) begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: run is only honoured on the final clock of a frame once running.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (h_last_s && v_last_s && !run) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Position LEAD clocks ahead; a frame-crossing request is only made if another frame follows.
    always_comb begin
        lead_h_s  = '0;
        lead_v_s  = '0;
        lead_ok_s = 1'b0;
        if (int'(h_cnt_s) >= H_TOTAL - LEAD) begin
            lead_h_s = CNT_W'(int'(h_cnt_s) + LEAD - H_TOTAL);
            if (v_last_s) begin
                lead_v_s  = '0;
                lead_ok_s = run;
            end else begin
                lead_v_s  = v_cnt_s + CNT_W'(1);
                lead_ok_s = 1'b1;
            end
        end else begin
            lead_h_s  = CNT_W'(int'(h_cnt_s) + LEAD);
            lead_v_s  = v_cnt_s;
            lead_ok_s = 1'b1;
        end
    end

    // Output decode from the current counters; registered below for one clock of latency.
    always_comb begin
        hsync_n_s     = ~(running_s && (h_region_s == REG_SYNC));
        vsync_n_s     = ~(running_s && (v_region_s == REG_SYNC));
        de_s          = running_s && (h_region_s == REG_ACTIVE) && (v_region_s == REG_ACTIVE);
        line_start_s  = running_s && (h_cnt_s == '0);
        frame_start_s = running_s && (h_cnt_s == '0) && (v_cnt_s == '0);
        pixel_req_s   = running_s && lead_ok_s
                        && (int'(lead_h_s) < H_ACTIVE) && (int'(lead_v_s) < V_ACTIVE);
        if (pixel_req_s) begin
            pixel_x_s = lead_h_s;
            pixel_y_s = lead_v_s;
        end else begin
            pixel_x_s = pixel_x_r;
            pixel_y_s = pixel_y_r;
        end
    end

    // Output registers; a low clock enable freezes all of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            de_r          <= 1'b0;
            pixel_req_r   <= 1'b0;
            pixel_x_r     <= '0;
            pixel_y_r     <= '0;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
            frame_count_r <= '0;
        end else if (clk__enable) begin
            hsync_n_r     <= hsync_n_s;
            vsync_n_r     <= vsync_n_s;
            de_r          <= de_s;
            pixel_req_r   <= pixel_req_s;
            pixel_x_r     <= pixel_x_s;
            pixel_y_r     <= pixel_y_s;
            frame_start_r <= frame_start_s;
            line_start_r  <= line_start_s;
            if (frame_end_s) begin
                frame_count_r <= frame_count_r + FRAME_CNT_W'(1);
            end
        end
    end

    assign lcd.hsync_n        = hsync_n_r;
    assign lcd.vsync_n        = vsync_n_r;
    assign lcd.display_enable = de_r;
    assign pixel_req          = pixel_req_r;
    assign pixel_x            = pixel_x_r;
    assign pixel_y            = pixel_y_r;
    assign frame_start        = frame_start_r;
    assign line_start         = line_start_r;
    assign frame_count        = frame_count_r;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen on a tiny raster (7x5 clocks) with LEAD equal to the blanking width.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

    localparam int HA = 4, HFP = 1, HS = 1, HB = 1;
    localparam int VA = 2, VFP = 1, VS = 1, VB = 1;
    localparam int LD = 3, CW = 4;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FT = HT * VT;
    localparam int OW = 14 + 2 * CW;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b1;
    logic          pixel_req, frame_start, line_start;
    logic [CW-1:0] pixel_x, pixel_y;
    logic [7:0]    frame_count;

    int errors = 0;
    int checks = 0;

    lcd_timing_gen_if lcd_bus ();

    lcd_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
        .LEAD     (LD), .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .clk__enable (clk_en),
        .reset       (reset),
        .run         (run),
        .lcd         (lcd_bus),
        .pixel_req   (pixel_req),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: a linear raster position within the frame, decoded with div/mod.
    int            m_pos = 0;
    int            m_fc = 0;
    logic          m_run = 1'b0;
    int            q_pos;
    logic          q_ok;
    logic          e_hs, e_vs, e_de, e_req, e_fs, e_ls;
    logic [CW-1:0] e_x, e_y;
    logic [OW-1:0] obs_vec, exp_vec;

    function automatic logic active_at(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic in_band(input int v, input int lo, input int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    always_comb begin
        q_pos = m_pos + LD;
        q_ok  = 1'b1;
        if (q_pos >= FT) begin
            q_pos = q_pos - FT;
            q_ok  = run;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_run <= 1'b0; m_pos <= 0; m_fc <= 0;
            e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_req <= 1'b0;
            e_fs <= 1'b0; e_ls <= 1'b0; e_x <= '0; e_y <= '0;
        end else if (clk_en) begin
            e_de  <= m_run && active_at(m_pos);
            e_hs  <= !(m_run && in_band(m_pos % HT, HA + HFP, HS));
            e_vs  <= !(m_run && in_band(m_pos / HT, VA + VFP, VS));
            e_ls  <= m_run && (m_pos % HT == 0);
            e_fs  <= m_run && (m_pos == 0);
            e_req <= m_run && q_ok && active_at(q_pos);
            if (m_run && q_ok && active_at(q_pos)) begin
                e_x <= CW'(q_pos % HT);
                e_y <= CW'(q_pos / HT);
            end
            if (!m_run) begin
                m_run <= run;
            end else if (m_pos == FT - 1) begin
                m_pos <= 0;
                m_fc  <= (m_fc + 1) % 256;
                m_run <= run;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    assign obs_vec = {lcd_bus.hsync_n, lcd_bus.vsync_n, lcd_bus.display_enable, pixel_req,
                      pixel_x, pixel_y, frame_start, line_start, frame_count};
    assign exp_vec = {e_hs, e_vs, e_de, e_req, e_x, e_y, e_fs, e_ls, 8'(m_fc)};

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; clk_en = 1'b0;
        step_cycle();
        step_cycle();
        checks++;
        if ({lcd_bus.hsync_n, lcd_bus.vsync_n, lcd_bus.display_enable, pixel_req,
             frame_start, line_start} !== 6'b110000 || pixel_x !== '0 || pixel_y !== '0
            || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want hs/vs=1 others=0", obs_vec);
        end
    endtask

    task automatic test_free_run();
        logic          de_h[256], req_h[256], hs_h[256], vs_h[256], ls_h[256];
        logic [CW-1:0] rx_h[256], ry_h[256];
        int            fidx[$];
        int            f1, f2, n_de, n_req, n_hs, n_vs, n_ls, k;
        reset = 1'b1; run = 1'b1; clk_en = 1'b1;
        step_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3 * FT + 4; c++) begin
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL free_run_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            de_h[c] = lcd_bus.display_enable; req_h[c] = pixel_req;
            hs_h[c] = lcd_bus.hsync_n; vs_h[c] = lcd_bus.vsync_n; ls_h[c] = line_start;
            rx_h[c] = pixel_x; ry_h[c] = pixel_y;
            if (frame_start === 1'b1) fidx.push_back(c);
        end
        checks++;
        if (fidx.size() < 3) begin
            errors++;
            $display("FAIL free_run_frames got=%0d want>=3", fidx.size());
        end else begin
            f1 = fidx[1]; f2 = fidx[2];
            n_de = 0; n_req = 0; n_hs = 0; n_vs = 0; n_ls = 0; k = 0;
            for (int c = f1; c < f2; c++) begin
                n_de  += int'(de_h[c]);
                n_req += int'(req_h[c]);
                n_hs  += int'(!hs_h[c]);
                n_vs  += int'(!vs_h[c]);
                n_ls  += int'(ls_h[c]);
            end
            checks++;
            if (f2 - f1 != FT) begin
                errors++; $display("FAIL frame_period got=%0d want=%0d", f2 - f1, FT);
            end
            checks++;
            if (n_de != HA * VA || n_req != HA * VA) begin
                errors++; $display("FAIL de_req_count got de=%0d req=%0d want=%0d", n_de, n_req, HA * VA);
            end
            checks++;
            if (n_hs != HS * VT || n_vs != VS * HT || n_ls != VT) begin
                errors++;
                $display("FAIL sync_counts got hs=%0d vs=%0d ls=%0d want %0d %0d %0d",
                         n_hs, n_vs, n_ls, HS * VT, VS * HT, VT);
            end
            for (int c = f1; c < f2; c++) begin
                if (ls_h[c]) begin
                    checks++;
                    if (hs_h[c + HA + HFP] !== 1'b0 || hs_h[c + HA + HFP - 1] !== 1'b1) begin
                        errors++; $display("FAIL hsync_start line_start=%0d got=%b%b want=10",
                                           c, hs_h[c + HA + HFP - 1], hs_h[c + HA + HFP]);
                    end
                end
                if (de_h[c]) begin
                    checks++;
                    if (!req_h[c - LD] || rx_h[c - LD] !== CW'(k % HA) || ry_h[c - LD] !== CW'(k / HA)) begin
                        errors++;
                        $display("FAIL lead_req pixel=%0d got req=%b x=%0d y=%0d want req=1 x=%0d y=%0d",
                                 k, req_h[c - LD], rx_h[c - LD], ry_h[c - LD], k % HA, k / HA);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic test_clk_enable();
        logic [OW-1:0] prev;
        logic          prev_fs, en_now;
        int            rises[$];
        run = 1'b1;
        prev = obs_vec; prev_fs = frame_start;
        for (int c = 0; c < 6 * FT + 12; c++) begin
            clk_en = (c % 3 == 0);
            en_now = clk_en;
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL clk_en_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (!en_now) begin
                checks++;
                if (obs_vec !== prev) begin
                    errors++; $display("FAIL clk_en_freeze cycle=%0d got=%h want=%h", c, obs_vec, prev);
                end
            end
            if (frame_start === 1'b1 && prev_fs !== 1'b1) rises.push_back(c);
            prev = obs_vec; prev_fs = frame_start;
        end
        checks++;
        if (rises.size() < 2 || rises[1] - rises[0] != 3 * FT) begin
            errors++;
            $display("FAIL clk_en_period got rises=%0d gap=%0d want gap=%0d",
                     rises.size(), (rises.size() >= 2) ? rises[1] - rises[0] : 0, 3 * FT);
        end
    endtask

    task automatic test_run_drop();
        logic       found = 1'b0;
        logic       done = 1'b0;
        logic [7:0] fc0;
        run = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 2 * FT && !found; c++) begin
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL run_drop_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (m_run && (m_pos / HT == 1)) found = 1'b1;
        end
        run = 1'b0;
        fc0 = frame_count;
        for (int c = 0; c < FT + 2 && !done; c++) begin
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL run_drop_finish cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (frame_count !== fc0) done = 1'b1;
        end
        checks++;
        if (!found || !done || frame_count !== fc0 + 8'd1) begin
            errors++;
            $display("FAIL run_drop_count got=%0d want=%0d (line1 seen=%b wrap seen=%b)",
                     frame_count, fc0 + 8'd1, found, done);
        end
        for (int c = 0; c < 8; c++) step_cycle();
        checks++;
        if (lcd_bus.hsync_n !== 1'b1 || lcd_bus.vsync_n !== 1'b1 || lcd_bus.display_enable !== 1'b0
            || pixel_req !== 1'b0 || frame_start !== 1'b0 || frame_count !== fc0 + 8'd1) begin
            errors++; $display("FAIL run_drop_idle got=%h want idle with count=%0d", obs_vec, fc0 + 8'd1);
        end
        run = 1'b1;
        step_cycle();
        step_cycle();
        checks++;
        if (frame_start !== 1'b1 || line_start !== 1'b1) begin
            errors++; $display("FAIL run_restart got fs=%b ls=%b want 1 1", frame_start, line_start);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic found = 1'b0;
        run = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 3 * FT && !found; c++) begin
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL reset_mid_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (lcd_bus.hsync_n === 1'b0 && (m_pos / HT == 1)) found = 1'b1;
        end
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        checks++;
        if (!found || lcd_bus.hsync_n !== 1'b1 || frame_count !== 8'd0 || pixel_x !== '0
            || pixel_y !== '0 || lcd_bus.display_enable !== 1'b0 || pixel_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame got=%h want hs=1 count=0 xy=0 (hsync seen=%b)", obs_vec, found);
        end
        step_cycle();
        checks++;
        if (lcd_bus.hsync_n !== 1'b1 || obs_vec !== exp_vec) begin
            errors++; $display("FAIL reset_mid_after got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_count_wrap();
        logic       saw = 1'b0;
        logic [7:0] prev;
        run = 1'b1; clk_en = 1'b1;
        prev = frame_count;
        for (int c = 0; c < 260 * FT && !saw; c++) begin
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL count_wrap_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (prev === 8'd255 && frame_count === 8'd0) saw = 1'b1;
            prev = frame_count;
        end
        checks++;
        if (!saw) begin
            errors++; $display("FAIL count_wrap got last=%0d want 255->0 seen", frame_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            reset = ($urandom_range(0, 149) == 0);
            step_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random_model cycle=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_clk_enable();
        test_run_drop();
        test_reset_mid_frame();
        test_count_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
